tqvp_integrator_seq: RTL and testbench

//  Burst sequencer for the 8-bit-in / 16-bit-acc integrator core: buffers samples in a small FIFO,

---
 rtl/tqvp_integrator_seq.sv | 206 ++++++++++++++++++++
 tb/tb_tqvp_integrator_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_integrator_seq.sv
// Burst sequencer feeding the integrator core from a small sample FIFO at a programmed interval.
// Optional build macro INTSEQ_HOLD_LAST_EN: on FIFO underrun, re-issue last_sample instead of stalling.
module tqvp_integrator_seq #(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IVL_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [7:0]                    burst_len,
  input  logic [IVL_W-1:0]              interval,
  input  logic [ACC_W-1:0]              thresh,
  input  logic                          irq_clr,
  input  logic                          push_valid,
  input  logic [IN_W-1:0]               push_data,
  output logic                          push_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          core_enable,
  output logic                          core_strobe,
  output logic [IN_W-1:0]               core_sample,
  input  logic [ACC_W-1:0]              acc_in,
  output logic                          busy,
  output logic                          done,
  output logic                          underrun,
  output logic                          irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_remaining;
  logic [IVL_W-1:0]  r_ivl_cnt;
  logic [IVL_W-1:0]  r_ivl_reload;
  logic [IN_W-1:0]   r_last_sample;
  logic              r_use_last;
  logic              r_issue_d;
  logic              r_irq;
  logic              r_underrun;

  logic [IN_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [IN_W-1:0]   w_head;
  logic              w_set_irq;
  logic              w_set_underrun;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_push  = push_valid & ~w_full;
  assign w_pop   = (r_state == S_ISSUE) & ~r_use_last;
  assign w_head  = r_use_last ? r_last_sample : r_mem[r_rd_ptr];

  assign w_set_underrun = (r_state == S_WAIT) && (r_ivl_cnt == '0) && w_empty;
  assign w_set_irq      = (r_state == S_DONE) ||
                          (r_issue_d && ($signed(acc_in) > $signed(thresh)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (burst_len != 8'd0) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (r_ivl_cnt == '0) begin
`ifdef INTSEQ_HOLD_LAST_EN
          w_next = S_ISSUE;
`else
          if (!w_empty) w_next = S_ISSUE;
`endif
        end
      end
      S_ISSUE: w_next = (r_remaining == 8'd1) ? S_DONE : S_WAIT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // State-decoded outputs
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    core_enable = 1'b0;
    core_strobe = 1'b0;
    core_sample = '0;
    case (r_state)
      S_WAIT: begin
        busy        = 1'b1;
        core_enable = 1'b1;
      end
      S_ISSUE: begin
        busy        = 1'b1;
        core_enable = 1'b1;
        core_strobe = 1'b1;
        core_sample = w_head;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Burst counters and sample hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining   <= '0;
      r_ivl_cnt     <= '0;
      r_ivl_reload  <= '0;
      r_last_sample <= '0;
      r_use_last    <= 1'b0;
      r_issue_d     <= 1'b0;
    end else begin
      r_issue_d <= (r_state == S_ISSUE);
      case (r_state)
        S_IDLE: begin
          r_use_last <= 1'b0;
          if (start && (burst_len != 8'd0)) begin
            r_remaining  <= burst_len;
            r_ivl_cnt    <= interval;
            r_ivl_reload <= interval;
          end
        end
        S_WAIT: begin
          if (r_ivl_cnt != '0) r_ivl_cnt <= r_ivl_cnt - IVL_W'(1);
`ifdef INTSEQ_HOLD_LAST_EN
          else r_use_last <= w_empty;
`endif
        end
        S_ISSUE: begin
          r_last_sample <= w_head;
          r_remaining   <= r_remaining - 8'd1;
          r_ivl_cnt     <= r_ivl_reload;
        end
        default: ;
      endcase
    end
  end

  // Sample FIFO
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign push_ready = ~w_full;
  assign fifo_level = r_level;

  // Sticky flags: a set event in the same cycle beats irq_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_set_irq)           r_irq <= 1'b1;
      else if (irq_clr)        r_irq <= 1'b0;
      if (w_set_underrun)      r_underrun <= 1'b1;
      else if (irq_clr)        r_underrun <= 1'b0;
    end
  end

  assign irq      = r_irq;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_tqvp_integrator_seq.sv
// Self-checking bench for tqvp_integrator_seq: directed scenarios plus randomized traffic vs a cycle-schedule model.
module tb_tqvp_integrator_seq;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [15:0] interval = '0;
  logic [15:0] thresh = '0;
  logic        irq_clr = 1'b0;
  logic        push_valid = 1'b0;
  logic [7:0]  push_data = '0;
  logic        push_ready;
  logic [2:0]  fifo_level;
  logic        core_enable;
  logic        core_strobe;
  logic [7:0]  core_sample;
  logic [15:0] acc_in = '0;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        irq;

  always #5 clk = ~clk;

  tqvp_integrator_seq #(
    .IN_W(8), .ACC_W(16), .FIFO_DEPTH(D), .IVL_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .burst_len(burst_len), .interval(interval), .thresh(thresh),
    .irq_clr(irq_clr), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .fifo_level(fifo_level),
    .core_enable(core_enable), .core_strobe(core_strobe), .core_sample(core_sample),
    .acc_in(acc_in), .busy(busy), .done(done), .underrun(underrun), .irq(irq)
  );

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  // Model: FIFO as a queue, burst progress as absolute cycle numbers of the next events
  logic [7:0] q[$];
  bit         m_active;
  longint     m_check_at, m_strobe_at, m_done_at;
  bit         m_use_last;
  logic [7:0] m_last;
  int         m_left, m_ivl;
  bit         m_irq, m_und, m_prev_strobe;

  longint     st_cyc[$];
  logic [7:0] st_val[$];
  longint     dn_cyc[$];
  longint     s_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic void model_reset();
    q.delete();
    m_active = 0; m_check_at = -1; m_strobe_at = -1; m_done_at = -1;
    m_use_last = 0; m_last = '0; m_left = 0; m_ivl = 0;
    m_irq = 0; m_und = 0; m_prev_strobe = 0;
  endfunction

  function automatic bit abort_ok();
    return m_active && (cyc != m_strobe_at) && (cyc != m_done_at);
  endfunction

  task automatic model_update(input bit e_strobe, input bit e_done, input logic [7:0] e_sample);
    bit was_active = m_active;
    int pre_size = q.size();
    bit set_irq = m_prev_strobe && ($signed(acc_in) > $signed(thresh));
    bit set_und = 0;
    if (e_strobe) begin
      if (!m_use_last) void'(q.pop_front());
      m_last = e_sample;
      m_left--;
      m_strobe_at = -1;
      if (m_left == 0) m_done_at = cyc + 1;
      else m_check_at = cyc + 1 + m_ivl;
    end else if (m_active && m_check_at >= 0 && cyc >= m_check_at) begin
      if (pre_size != 0) begin
        m_strobe_at = cyc + 1; m_use_last = 0; m_check_at = -1;
      end else begin
        set_und = 1;
`ifdef INTSEQ_HOLD_LAST_EN
        m_strobe_at = cyc + 1; m_use_last = 1; m_check_at = -1;
`endif
      end
    end
    if (e_done) begin
      set_irq = 1; m_active = 0; m_done_at = -1;
    end
    if (abort && was_active) begin
      m_active = 0; m_check_at = -1; m_strobe_at = -1; m_done_at = -1;
    end
    if (start && !was_active) begin
      m_active = 1;
      if (burst_len != 0) begin
        m_left = burst_len; m_ivl = interval; m_check_at = cyc + 1 + interval;
      end else m_done_at = cyc + 1;
    end
    if (push_valid && pre_size < D) q.push_back(push_data);
    if (irq_clr) begin m_irq = 0; m_und = 0; end
    if (set_irq) m_irq = 1;
    if (set_und) m_und = 1;
    m_prev_strobe = e_strobe;
  endtask

  // One clock cycle: compare every output against the model, then advance the model
  task automatic step();
    bit e_strobe, e_done;
    logic [7:0] e_sample;
    @(negedge clk);
    e_done   = m_active && (cyc == m_done_at);
    e_strobe = m_active && (cyc == m_strobe_at);
    e_sample = '0;
    if (e_strobe) e_sample = m_use_last ? m_last : ((q.size() > 0) ? q[0] : 8'h00);
    chk("busy",        busy,        m_active);
    chk("done",        done,        e_done);
    chk("core_strobe", core_strobe, e_strobe);
    chk("core_enable", core_enable, m_active && !e_done);
    chk("core_sample", core_sample, e_sample);
    chk("fifo_level",  fifo_level,  q.size());
    chk("push_ready",  push_ready,  q.size() < D);
    chk("irq",         irq,         m_irq);
    chk("underrun",    underrun,    m_und);
    if (start) s_cyc = cyc;
    if (core_strobe) begin st_cyc.push_back(cyc); st_val.push_back(core_sample); end
    if (done) dn_cyc.push_back(cyc);
    model_update(e_strobe, e_done, e_sample);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_until_strobe(input int bound);
    int n0 = st_cyc.size();
    for (int i = 0; i < bound && st_cyc.size() == n0; i++) step();
    if (st_cyc.size() == n0) timeout("strobe_wait");
  endtask

  task automatic run_until_done(input int bound);
    int n0 = dn_cyc.size();
    for (int i = 0; i < bound && dn_cyc.size() == n0; i++) step();
    if (dn_cyc.size() == n0) timeout("done_wait");
  endtask

  task automatic do_reset();
    start = 0; abort = 0; push_valid = 0; irq_clr = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_enable", core_enable, 0);
    chk("rst_strobe", core_strobe, 0);
    chk("rst_sample", core_sample, 0);
    chk("rst_ready",  push_ready, 1);
    chk("rst_level",  fifo_level, 0);
    chk("rst_irq",    irq, 0);
    chk("rst_under",  underrun, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc++;
    model_reset();
  endtask

  function automatic void clear_logs();
    st_cyc.delete(); st_val.delete(); dn_cyc.delete();
  endfunction

  function automatic logic [31:0] qv(input longint v[$], input int i);
    return (v.size() > i) ? 32'(v[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int n;
    model_reset();
    #12;
    do_reset();

    // T1: three samples, interval 2
    clear_logs();
    push_valid = 1; push_data = 8'd3; step();
    push_data = 8'd5; step();
    push_data = 8'd7; step();
    push_valid = 0;
    interval = 16'd2; burst_len = 8'd3; start = 1; step();
    start = 0;
    run_until_done(40);
    chk("t1_nstrobe", st_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_strobe_cyc", qv(st_cyc, i), 32'(s_cyc + 4 * (i + 1)));
      chk("t1_strobe_val", (st_val.size() > i) ? 32'(st_val[i]) : 32'hFFFF_FFFF, 32'(3 + 2 * i));
    end
    chk("t1_done_cyc", qv(dn_cyc, 0), 32'(s_cyc + 13));
    chk("t1_irq", irq, 1);

    // T2: burst started with an empty FIFO
    do_reset();
    clear_logs();
    burst_len = 8'd2; interval = 16'd1; start = 1; step();
    start = 0;
`ifdef INTSEQ_HOLD_LAST_EN
    run_until_strobe(10);
    chk("t2_hold_cyc", qv(st_cyc, 0), 32'(s_cyc + 3));
    chk("t2_hold_val", (st_val.size() > 0) ? 32'(st_val[0]) : 32'hFFFF_FFFF, 0);
    chk("t2_underrun", underrun, 1);
    run_until_done(20);
`else
    repeat (6) step();
    chk("t2_underrun", underrun, 1);
    chk("t2_nostrobe", st_cyc.size(), 0);
    push_valid = 1; push_data = 8'd9; n = int'(cyc); step();
    push_valid = 0;
    run_until_strobe(10);
    chk("t2_strobe_cyc", qv(st_cyc, 0), 32'(n + 2));
    chk("t2_strobe_val", (st_val.size() > 0) ? 32'(st_val[0]) : 32'hFFFF_FFFF, 9);
    push_valid = 1; push_data = 8'd4; step();
    push_valid = 0;
    run_until_done(20);
`endif

    // T3: overfill the FIFO
    for (int i = 1; i <= 5; i++) begin
      push_valid = 1; push_data = 8'(i * 16); step();
      if (i == 3) chk("t3_ready3", push_ready, 1);
      if (i == 4) begin chk("t3_level4", fifo_level, 4); chk("t3_ready4", push_ready, 0); end
    end
    push_valid = 0;
    chk("t3_level5", fifo_level, 4);

    // T4: abort after the first strobe
    clear_logs();
    interval = 16'd1; burst_len = 8'd4; start = 1; step();
    start = 0;
    run_until_strobe(10);
    chk("t4_val", (st_val.size() > 0) ? 32'(st_val[0]) : 32'hFFFF_FFFF, 16);
    abort = 1; step();
    abort = 0;
    chk("t4_busy", busy, 0);
    chk("t4_level", fifo_level, 3);
    repeat (6) step();
    chk("t4_nostrobe", st_cyc.size(), 1);
    chk("t4_nodone", dn_cyc.size(), 0);

    // T5: signed threshold
    irq_clr = 1; step(); irq_clr = 0;
    chk("t5_clr0", irq, 0);
    thresh = 16'sd10; interval = 16'd0; burst_len = 8'd2; start = 1; step();
    start = 0;
    run_until_strobe(10);
    acc_in = 16'sd11; abort = 1; step();
    abort = 0; acc_in = '0;
    chk("t5_irq_set", irq, 1);
    irq_clr = 1; step(); irq_clr = 0;
    chk("t5_irq_clr", irq, 0);
    thresh = 16'hFFFF; acc_in = 16'hFFFF; start = 1; step();
    start = 0;
    run_until_strobe(10);
    abort = 1; step();
    abort = 0;
    chk("t5_no_irq", irq, 0);

    // T6: reset in the middle of WAIT
    interval = 16'd3; burst_len = 8'd3; start = 1; step();
    start = 0;
    step(); step();
    chk("t6_busy_before", busy, 1);
    do_reset();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      push_valid = ($urandom_range(0, 3) < ((k < 1500) ? 1 : 2));
      push_data  = 8'($urandom);
      start      = ($urandom_range(0, 9) == 0);
      burst_len  = 8'($urandom_range(0, 6));
      interval   = 16'($urandom_range(0, 4));
      abort      = ($urandom_range(0, 49) == 0) && abort_ok();
      irq_clr    = ($urandom_range(0, 19) == 0);
      thresh     = 16'($urandom);
      acc_in     = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
